// File: rtl/lsu_bus_ctrl.sv
// lsu_bus_ctrl
//   Load/store bus controller between the CPU memory stage and a req/ack data bus.
//   Builds byte enables from size and address offset, replicates store data across
//   the byte lanes, waits for the slave ack (optionally bounded by TIMEOUT) and
//   returns right-justified, sign/zero-extended load data.
//
//   state | meaning
//   IDLE  | ready; req is sampled and checked for alignment
//   WAIT  | bus_req held until bus_ack or timeout
//   RESP  | one-cycle done pulse with rdata and error flags
//
// Ports
//   clk, rst                         clock, synchronous active-high reset
//   req, we, size, sext, addr, wdata CPU-side access request
//   busy, done, rdata                CPU-side status and load result
//   err_align, err_timeout           error flags, valid with done
//   bus_req, bus_we, bus_addr,
//   bus_be, bus_wdata                bus request side
//   bus_ack, bus_rdata               bus response side
module lsu_bus_ctrl #(
   parameter int DATA_W  = 32,
   parameter int ADDR_W  = 32,
   parameter int TIMEOUT = 16
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                req,
   input  logic                we,
   input  logic [1:0]          size,
   input  logic                sext,
   input  logic [ADDR_W-1:0]   addr,
   input  logic [DATA_W-1:0]   wdata,
   output logic                busy,
   output logic                done,
   output logic [DATA_W-1:0]   rdata,
   output logic                err_align,
   output logic                err_timeout,
   output logic                bus_req,
   output logic                bus_we,
   output logic [ADDR_W-1:0]   bus_addr,
   output logic [DATA_W/8-1:0] bus_be,
   output logic [DATA_W-1:0]   bus_wdata,
   input  logic                bus_ack,
   input  logic [DATA_W-1:0]   bus_rdata
);

   localparam int NB    = DATA_W / 8;
   localparam int OW    = $clog2(NB);
   // The counter only has to reach TIMEOUT-1; the expiring cycle is detected by compare.
   localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] CNT_TC = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

   state_t            state_q, state_d;
   logic              bus_req_q, bus_req_d;
   logic              bus_we_q, bus_we_d;
   logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
   logic [NB-1:0]     bus_be_q, bus_be_d;
   logic [DATA_W-1:0] bus_wdata_q, bus_wdata_d;
   logic [1:0]        size_q, size_d;
   logic              sext_q, sext_d;
   logic [OW-1:0]     off_q, off_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              done_q, done_d;
   logic              err_align_q, err_align_d;
   logic              err_timeout_q, err_timeout_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;

   logic [OW-1:0]     off_c;
   int                bytes_c;
   logic              legal_c;
   logic [NB-1:0]     be_c;
   logic [DATA_W-1:0] wd_c, sh_c, mask_c, ext_c;
   logic              msb_c;

   // request decode: enables, lane replication, alignment check
   always_comb begin
      off_c   = addr[OW-1:0];
      bytes_c = 1 << size;
      legal_c = (bytes_c <= NB) && ((int'(off_c) & (bytes_c - 1)) == 0);
      be_c    = '0;
      wd_c    = '0;
      for (int i = 0; i < NB; i++) begin
         be_c[i]       = (i >= int'(off_c)) && (i < int'(off_c) + bytes_c);
         wd_c[8*i +: 8] = wdata[8*(i & (bytes_c - 1)) +: 8];
      end
   end

   // load realignment; the field's top bit is the highest set bit of the mask
   always_comb begin
      sh_c   = bus_rdata >> (8 * int'(off_q));
      mask_c = '0;
      for (int i = 0; i < NB; i++) begin
         mask_c[8*i +: 8] = (i < (1 << size_q)) ? 8'hFF : 8'h00;
      end
      msb_c = |(sh_c & (mask_c ^ (mask_c >> 1)));
      ext_c = (sh_c & mask_c) | ((sext_q && msb_c) ? ~mask_c : '0);
   end

   always_comb begin
      state_d       = state_q;
      bus_req_d     = bus_req_q;
      bus_we_d      = bus_we_q;
      bus_addr_d    = bus_addr_q;
      bus_be_d      = bus_be_q;
      bus_wdata_d   = bus_wdata_q;
      size_d        = size_q;
      sext_d        = sext_q;
      off_d         = off_q;
      cnt_d         = cnt_q;
      done_d        = 1'b0;
      err_align_d   = 1'b0;
      err_timeout_d = 1'b0;
      rdata_d       = '0;
      case (state_q)
         S_IDLE: begin
            if (req) begin
               if (!legal_c) begin
                  state_d     = S_RESP;
                  done_d      = 1'b1;
                  err_align_d = 1'b1;
               end else begin
                  state_d     = S_WAIT;
                  bus_req_d   = 1'b1;
                  bus_we_d    = we;
                  bus_addr_d  = {addr[ADDR_W-1:OW], {OW{1'b0}}};
                  bus_be_d    = be_c;
                  bus_wdata_d = wd_c;
                  size_d      = size;
                  sext_d      = sext;
                  off_d       = off_c;
                  cnt_d       = '0;
               end
            end
         end
         S_WAIT: begin
            if (bus_ack) begin
               state_d     = S_RESP;
               done_d      = 1'b1;
               rdata_d     = bus_we_q ? '0 : ext_c;
               bus_req_d   = 1'b0;
               bus_we_d    = 1'b0;
               bus_be_d    = '0;
               bus_wdata_d = '0;
            end else if ((TIMEOUT != 0) && (cnt_q == CNT_TC)) begin
               state_d       = S_RESP;
               done_d        = 1'b1;
               err_timeout_d = 1'b1;
               bus_req_d     = 1'b0;
               bus_we_d      = 1'b0;
               bus_be_d      = '0;
               bus_wdata_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_RESP:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= S_IDLE;
         bus_req_q     <= 1'b0;
         bus_we_q      <= 1'b0;
         bus_addr_q    <= '0;
         bus_be_q      <= '0;
         bus_wdata_q   <= '0;
         size_q        <= '0;
         sext_q        <= 1'b0;
         off_q         <= '0;
         cnt_q         <= '0;
         done_q        <= 1'b0;
         err_align_q   <= 1'b0;
         err_timeout_q <= 1'b0;
         rdata_q       <= '0;
      end else begin
         state_q       <= state_d;
         bus_req_q     <= bus_req_d;
         bus_we_q      <= bus_we_d;
         bus_addr_q    <= bus_addr_d;
         bus_be_q      <= bus_be_d;
         bus_wdata_q   <= bus_wdata_d;
         size_q        <= size_d;
         sext_q        <= sext_d;
         off_q         <= off_d;
         cnt_q         <= cnt_d;
         done_q        <= done_d;
         err_align_q   <= err_align_d;
         err_timeout_q <= err_timeout_d;
         rdata_q       <= rdata_d;
      end
   end

   assign busy        = (state_q != S_IDLE);
   assign done        = done_q;
   assign rdata       = rdata_q;
   assign err_align   = err_align_q;
   assign err_timeout = err_timeout_q;
   assign bus_req     = bus_req_q;
   assign bus_we      = bus_we_q;
   assign bus_addr    = bus_addr_q;
   assign bus_be      = bus_be_q;
   assign bus_wdata   = bus_wdata_q;

endmodule

// File: tb/tb_lsu_bus_ctrl.sv
// Directed bench: instance a is 32-bit with TIMEOUT=4, instance b is 64-bit.
module tb_lsu_bus_ctrl;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic        a_req = 0, a_we = 0, a_sext = 0, a_ack = 0;
   logic [1:0]  a_size = 0;
   logic [31:0] a_addr = 0, a_wdata = 0, a_brdata = 0;
   logic        a_busy, a_done, a_ea, a_et, a_breq, a_bwe;
   logic [31:0] a_rdata, a_baddr, a_bwdata;
   logic [3:0]  a_be;

   logic        b_req = 0, b_we = 0, b_sext = 0, b_ack = 0;
   logic [1:0]  b_size = 0;
   logic [31:0] b_addr = 0;
   logic [63:0] b_wdata = 0, b_brdata = 0;
   logic        b_busy, b_done, b_ea, b_et, b_breq, b_bwe;
   logic [63:0] b_rdata, b_bwdata;
   logic [31:0] b_baddr;
   logic [7:0]  b_be;

   lsu_bus_ctrl #(.DATA_W(32), .ADDR_W(32), .TIMEOUT(4)) dut_a (
      .clk(clk), .rst(rst), .req(a_req), .we(a_we), .size(a_size), .sext(a_sext),
      .addr(a_addr), .wdata(a_wdata), .busy(a_busy), .done(a_done), .rdata(a_rdata),
      .err_align(a_ea), .err_timeout(a_et), .bus_req(a_breq), .bus_we(a_bwe),
      .bus_addr(a_baddr), .bus_be(a_be), .bus_wdata(a_bwdata), .bus_ack(a_ack),
      .bus_rdata(a_brdata));

   lsu_bus_ctrl #(.DATA_W(64), .ADDR_W(32), .TIMEOUT(16)) dut_b (
      .clk(clk), .rst(rst), .req(b_req), .we(b_we), .size(b_size), .sext(b_sext),
      .addr(b_addr), .wdata(b_wdata), .busy(b_busy), .done(b_done), .rdata(b_rdata),
      .err_align(b_ea), .err_timeout(b_et), .bus_req(b_breq), .bus_we(b_bwe),
      .bus_addr(b_baddr), .bus_be(b_be), .bus_wdata(b_bwdata), .bus_ack(b_ack),
      .bus_rdata(b_brdata));

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic a_issue(input logic w, input logic [1:0] s, input logic sx,
                          input logic [31:0] ad, input logic [31:0] wd);
      a_req = 1; a_we = w; a_size = s; a_sext = sx; a_addr = ad; a_wdata = wd;
      tick();
      a_req = 0;
   endtask

   task automatic a_ack_with(input logic [31:0] rd);
      a_ack = 1; a_brdata = rd;
      tick();
      a_ack = 0; a_brdata = 0;
   endtask

   initial begin
      tick(); tick();
      chk("rst_busy", a_busy, 0);
      chk("rst_done", a_done, 0);
      chk("rst_breq", a_breq, 0);
      chk("rst_be", a_be, 0);
      chk("rst_bwdata", a_bwdata, 0);
      chk("rst_baddr", a_baddr, 0);
      chk("rst_rdata", a_rdata, 0);
      chk("rst_b_be", b_be, 0);
      rst = 0;
      tick();

      // ack while idle must be ignored
      a_ack = 1; a_brdata = 32'hFFFF_FFFF;
      tick();
      a_ack = 0;
      chk("idle_ack_busy", a_busy, 0);
      chk("idle_ack_done", a_done, 0);

      // T1 byte store at offset 3
      a_issue(1, 2'b00, 0, 32'h1003, 32'hAB);
      chk("t1_breq", a_breq, 1);
      chk("t1_bwe", a_bwe, 1);
      chk("t1_be", a_be, 4'b1000);
      chk("t1_wdata", a_bwdata, 32'hABAB_ABAB);
      chk("t1_addr", a_baddr, 32'h1000);
      chk("t1_done_early", a_done, 0);
      a_ack_with(32'h5555_5555);
      chk("t1_done", a_done, 1);
      chk("t1_rdata", a_rdata, 0);
      chk("t1_breq_drop", a_breq, 0);
      chk("t1_be_drop", a_be, 0);
      tick();
      chk("t1_idle_done", a_done, 0);
      chk("t1_idle_busy", a_busy, 0);

      // T2 half load, sign then zero extension
      a_issue(0, 2'b01, 1, 32'h2, 0);
      chk("t2_be", a_be, 4'b1100);
      chk("t2_done_early", a_done, 0);
      a_ack_with(32'h8001_1234);
      chk("t2_done", a_done, 1);
      chk("t2_sext", a_rdata, 32'hFFFF_8001);
      chk("t2_err", {a_ea, a_et}, 0);
      tick();
      a_issue(0, 2'b01, 0, 32'h2, 0);
      a_ack_with(32'h8001_1234);
      chk("t2_zext", a_rdata, 32'h0000_8001);
      tick();

      // byte load from lane 3 with sign extension
      a_issue(0, 2'b00, 1, 32'h7, 0);
      chk("byte_be", a_be, 4'b1000);
      a_ack_with(32'h80FF_FFFF);
      chk("byte_sext", a_rdata, 32'hFFFF_FF80);
      tick();

      // T3 misaligned word; req held through RESP must be ignored
      a_req = 1; a_we = 0; a_size = 2'b10; a_addr = 32'h6;
      tick();
      chk("t3_done", a_done, 1);
      chk("t3_align", a_ea, 1);
      chk("t3_breq", a_breq, 0);
      chk("t3_rdata", a_rdata, 0);
      tick();
      a_req = 0;
      chk("t3_resp_req_ignored", a_busy, 0);
      chk("t3_done_clear", a_done, 0);
      chk("t3_breq2", a_breq, 0);
      tick();

      // dword on a 32-bit bus is illegal
      a_issue(0, 2'b11, 0, 32'h0, 0);
      chk("dw32_align", {a_done, a_ea, a_breq}, 3'b110);
      tick();

      // T4 timeout: bus_req high for exactly 4 cycles
      a_issue(0, 2'b10, 0, 32'h10, 0);
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("t4_breq_%0d", i), {a_breq, a_done}, 2'b10);
         tick();
      end
      chk("t4_breq_drop", a_breq, 0);
      chk("t4_done", a_done, 1);
      chk("t4_timeout", a_et, 1);
      chk("t4_rdata", a_rdata, 0);
      tick();
      chk("t4_clear", {a_done, a_et, a_busy}, 0);

      // ack on the 4th WAIT cycle wins over expiry
      a_issue(0, 2'b10, 0, 32'h10, 0);
      for (int i = 0; i < 3; i++) tick();
      chk("t4b_breq", a_breq, 1);
      a_ack_with(32'h1234_5678);
      chk("t4b_done", a_done, 1);
      chk("t4b_noerr", a_et, 0);
      chk("t4b_rdata", a_rdata, 32'h1234_5678);
      tick();

      // T5 reset in the second WAIT cycle
      a_issue(0, 2'b10, 0, 32'h20, 0);
      tick();
      chk("t5_in_wait", a_breq, 1);
      rst = 1;
      tick();
      rst = 0;
      chk("t5_rst_outs", {a_busy, a_done, a_breq, a_bwe, a_ea, a_et}, 0);
      chk("t5_rst_buses", {a_be, a_bwdata, a_baddr}, 0);
      chk("t5_rst_rdata", a_rdata, 0);
      tick();
      chk("t5_no_done", a_done, 0);
      a_issue(1, 2'b01, 0, 32'h0, 32'h1234);
      chk("t5_be", a_be, 4'b0011);
      chk("t5_wdata", a_bwdata, 32'h1234_1234);
      a_ack_with(0);
      chk("t5_done", {a_done, a_ea, a_et}, 3'b100);
      tick();

      // T6 64-bit instance
      b_req = 1; b_we = 1; b_size = 2'b11; b_addr = 32'h8; b_wdata = 64'h1122_3344_5566_7788;
      tick();
      b_req = 0;
      chk("t6_be", b_be, 8'hFF);
      chk("t6_wdata", b_bwdata, 64'h1122_3344_5566_7788);
      chk("t6_addr", b_baddr, 32'h8);
      b_ack = 1;
      tick();
      b_ack = 0;
      chk("t6_done", {b_done, b_ea, b_et}, 3'b100);
      tick();
      b_req = 1; b_we = 0; b_size = 2'b10; b_sext = 0; b_addr = 32'h4;
      tick();
      b_req = 0;
      chk("t6_ld_be", b_be, 8'hF0);
      chk("t6_ld_addr", b_baddr, 32'h0);
      b_ack = 1; b_brdata = 64'h1234_5678_0000_0000;
      tick();
      b_ack = 0;
      chk("t6_ld_done", b_done, 1);
      chk("t6_ld_rdata", b_rdata, 64'h1234_5678);
      tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
